// File: rtl/rsa_modexp_engine.sv
// Modular exponentiation core: base^exponent mod modulus, computed with right-to-left
// square-and-multiply on top of a bit-serial interleaved modular multiplier.
module rsa_modexp_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] Cal_val,
  output logic             Cal_done,
  output logic             Busy,
  output logic             Err
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, REDUCE, CHECK, MUL, SQR, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] m_q, e_q, b_q, r_q;
  logic [WIDTH-1:0] mm_a, mm_b;
  logic [WIDTH:0]   acc;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH:0]   m_ext, t_dbl, t_red1, t_add, step;
  logic [WIDTH-1:0] step_w;

  assign last   = (cnt == CW'(WIDTH - 1));
  assign m_ext  = {1'b0, m_q};
  assign step_w = step[WIDTH-1:0];

  // One interleaved step: double, reduce, conditionally add A, reduce.
  always_comb begin
    t_dbl  = acc << 1;
    t_red1 = (t_dbl >= m_ext) ? (t_dbl - m_ext) : t_dbl;
    t_add  = mm_b[WIDTH-1] ? (t_red1 + {1'b0, mm_a}) : t_red1;
    step   = (t_add >= m_ext) ? (t_add - m_ext) : t_add;
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_n;
  end

  // A zero modulus routes through CHECK with e forced to 0, so Cal_done lands
  // one cycle after Start like every other completion path through CHECK.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (Start) state_n = (modulus == '0) ? CHECK : REDUCE;
      REDUCE:  if (last) state_n = CHECK;
      CHECK: begin
        if (e_q == '0)  state_n = DONE;
        else if (e_q[0]) state_n = MUL;
        else             state_n = SQR;
      end
      MUL:     if (last) state_n = (e_q[WIDTH-1:1] != '0) ? SQR : CHECK;
      SQR:     if (last) state_n = CHECK;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      m_q     <= '0;
      e_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      mm_a    <= '0;
      mm_b    <= '0;
      acc     <= '0;
      cnt     <= '0;
      Cal_val <= '0;
      Err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            m_q  <= modulus;
            e_q  <= (modulus == '0) ? '0 : exponent;
            r_q  <= (modulus <= WIDTH'(1)) ? '0 : WIDTH'(1);
            mm_a <= WIDTH'(1);
            mm_b <= base;
            acc  <= '0;
            cnt  <= '0;
            Err  <= (modulus == '0);
          end
        end
        REDUCE, MUL, SQR: begin
          acc  <= last ? '0 : step;
          mm_b <= mm_b << 1;
          cnt  <= last ? '0 : cnt + 1'b1;
          if (last) begin
            if (state == REDUCE) begin
              // modmul(1, x) is only valid for M > 1; M == 1 must give 0.
              b_q <= (m_q == WIDTH'(1)) ? '0 : step_w;
            end else if (state == MUL) begin
              r_q <= step_w;
              if (e_q[WIDTH-1:1] != '0) begin
                mm_a <= b_q;
                mm_b <= b_q;
              end else begin
                e_q <= e_q >> 1;
              end
            end else begin
              b_q <= step_w;
              e_q <= e_q >> 1;
            end
          end
        end
        CHECK: begin
          mm_a <= e_q[0] ? r_q : b_q;
          mm_b <= b_q;
          acc  <= '0;
          cnt  <= '0;
          if (e_q == '0) Cal_val <= r_q;
        end
        default: ;
      endcase
    end
  end

  assign Cal_done = (state == DONE);
  assign Busy     = (state != IDLE);

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// Directed and model-checked stimulus for rsa_modexp_engine at WIDTH=16 and WIDTH=8.
module tb_rsa_modexp_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start8;
  logic [15:0] base16, exp16, mod16, val16;
  logic [7:0]  base8, exp8, mod8, val8;
  logic        done16, busy16, err16, done8, busy8, err8;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  rsa_modexp_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .Rst(rst_n), .Start(start16), .base(base16), .exponent(exp16),
    .modulus(mod16), .Cal_val(val16), .Cal_done(done16), .Busy(busy16), .Err(err16)
  );

  rsa_modexp_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .Rst(rst_n), .Start(start8), .base(base8), .exponent(exp8),
    .modulus(mod8), .Cal_val(val8), .Cal_done(done8), .Busy(busy8), .Err(err8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic logic [31:0] powmod(input longint b, input longint e, input longint m);
    longint r, bb, ee;
    r  = 1 % m;
    bb = b % m;
    ee = e;
    while (ee != 0) begin
      if (ee[0]) r = (r * bb) % m;
      bb = (bb * bb) % m;
      ee = ee >> 1;
    end
    return 32'(r);
  endfunction

  function automatic int latency(input int w, input logic [31:0] e);
    int n, p;
    n = -1;
    p = 0;
    if (e == 0) return w + 1;
    for (int i = 0; i < 32; i++) if (e[i]) begin n = i; p++; end
    return w + (n + 2) + w * (p + n);
  endfunction

  // pulse_at > 0: at that edge, pulse Start with different operands while busy.
  task automatic run16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       input logic [15:0] ev, input logic eerr, input int elat,
                       input string tag, input int pulse_at);
    int  n;
    bit  seen;
    @(negedge clk);
    base16 = b; exp16 = e; mod16 = m; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 2000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == pulse_at) begin
        base16 = 16'd5; exp16 = 16'd7; mod16 = 16'd11; start16 = 1'b1;
      end else begin
        start16 = 1'b0;
      end
      if (done16) seen = 1;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_val"}, val16, ev);
    check({tag, "_err"}, err16, eerr);
    check({tag, "_busy_in_done"}, busy16, 1);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done16, 0);
    check({tag, "_busy_after"}, busy16, 0);
  endtask

  task automatic run8(input logic [7:0] b, input logic [7:0] e, input logic [7:0] m,
                      input logic [7:0] ev, input int elat, input string tag);
    int n;
    bit seen;
    @(negedge clk);
    base8 = b; exp8 = e; mod8 = m; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (done8) seen = 1;
    end
    check({tag, "_lat"}, n, elat);
    check({tag, "_val"}, val8, ev);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, done8, 0);
  endtask

  initial begin
    logic [15:0] rb, re, rm;
    logic [7:0]  sb, se, sm;
    int          n;

    rst_n = 1'b0;
    start16 = 1'b0; base16 = '0; exp16 = '0; mod16 = '0;
    start8  = 1'b0; base8  = '0; exp8  = '0; mod8  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_val", val16, 0);
    check("reset_done", done16, 0);
    check("reset_busy", busy16, 0);
    check("reset_err", err16, 0);
    @(negedge clk) rst_n = 1'b1;

    run16(16'd9,   16'd3,  16'd33,   16'd3,  1'b0, 67,  "p9_3_33", 0);
    run16(16'd100, 16'd2,  16'd7,    16'd4,  1'b0, 51,  "p100_2_7", 0);
    run16(16'd5,   16'd0,  16'd7,    16'd1,  1'b0, 17,  "p5_0_7", 0);
    run16(16'd9,   16'd3,  16'd0,    16'd0,  1'b1, 1,   "mod0", 0);
    run16(16'd2,   16'd10, 16'd1000, 16'd24, 1'b0, 101, "err_clear", 0);
    run16(16'd12,  16'd5,  16'd1,    16'd0,  1'b0, 84,  "mod1", 0);
    run16(16'd9,   16'd3,  16'd33,   16'd3,  1'b0, 67,  "busy_start", 20);

    // Asynchronous reset while squaring (SQR spans edges 34..49 for 9^3 mod 33).
    @(negedge clk);
    base16 = 16'd9; exp16 = 16'd3; mod16 = 16'd33; start16 = 1'b1;
    @(posedge clk);
    #1 start16 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("pre_reset_busy", busy16, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_val", val16, 0);
    check("async_rst_busy", busy16, 0);
    check("async_rst_done", done16, 0);
    check("async_rst_err", err16, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run16(16'd9, 16'd3, 16'd33, 16'd3, 1'b0, 67, "after_rst", 0);

    for (int i = 0; i < 30; i++) begin
      rb = 16'($urandom_range(0, 65535));
      re = 16'($urandom_range(0, 65535));
      rm = 16'($urandom_range(2, 65535));
      run16(rb, re, rm, 16'(powmod(rb, re, rm)), 1'b0, latency(16, re),
            $sformatf("rnd16_%0d", i), 0);
    end

    run8(8'd200, 8'd255, 8'd251, 8'(powmod(200, 255, 251)), latency(8, 255), "w8_max");
    for (int i = 0; i < 120; i++) begin
      sb = 8'($urandom_range(0, 255));
      se = 8'($urandom_range(0, 255));
      sm = 8'($urandom_range(2, 255));
      run8(sb, se, sm, 8'(powmod(sb, se, sm)), latency(8, se), $sformatf("rnd8_%0d", i));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
